// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution accelerator stream blocks.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_W = 3'd1,
        SEND_B = 3'd2,
        SEND_X = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } tx_state_t;

    // Source of the word currently in flight towards the skid buffer.
    typedef enum logic [1:0] {
        SRC_W = 2'd0,
        SRC_B = 2'd1,
        SRC_X = 2'd2
    } tx_src_t;

    localparam int TUSER_NEWW_BIT = 0;
    localparam int TUSER_K_LSB    = 1;

endpackage

// File: rtl/conv_stream_tx_skid.sv
// Two-entry skid FIFO in front of the stream output; reports its occupancy
// so the reader can throttle RAM reads.
module axis_skid2 #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;

    assign valid = (occ != 2'd0);
    assign data  = mem[rd_ptr];
    assign pop   = valid & ready;

    // The writer guarantees push never lands on a full buffer unless a pop
    // happens in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/conv_stream_tx.sv
// Streams W, B and X words from the staging RAMs into the convolution
// accelerator input, with 1-cycle RAM latency hidden behind a 2-entry skid.
//
// state  | meaning
// IDLE   | waiting for a command, CMD_READY high
// SEND_W | reading W[0..K*K-1]
// SEND_B | injecting the latched bias word
// SEND_X | reading X[0..R*C-1]
// DRAIN  | waiting for the last word to leave the skid buffer
// DONE   | one-cycle completion pulse
module conv_stream_tx
    import conv_pkg::*;
#(
    parameter  int INW         = 24,
    parameter  int R           = 16,
    parameter  int C           = 17,
    parameter  int MAXK        = 9,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [K_BITS-1:0]      CMD_K,
    input  logic                   CMD_NEW_W,
    input  logic [INW-1:0]         CMD_B,
    output logic [X_ADDR_BITS-1:0] X_RD_ADDR,
    output logic                   X_RD_EN,
    input  logic [INW-1:0]         X_RD_DATA,
    output logic [W_ADDR_BITS-1:0] W_RD_ADDR,
    output logic                   W_RD_EN,
    input  logic [INW-1:0]         W_RD_DATA,
    output logic [INW-1:0]         OUTPUT_TDATA,
    output logic                   OUTPUT_TVALID,
    output logic [K_BITS:0]        OUTPUT_TUSER,
    input  logic                   OUTPUT_TREADY,
    output logic                   DONE,
    output logic                   CMD_ERR
);

    localparam int KK_BITS = W_ADDR_BITS + 1;

    tx_state_t              state;
    tx_src_t                pend_src;
    tx_src_t                src_now;
    logic [K_BITS-1:0]      k_q;
    logic                   new_w_q;
    logic [INW-1:0]         b_q;
    logic [W_ADDR_BITS-1:0] w_cnt;
    logic [X_ADDR_BITS-1:0] x_cnt;
    logic                   pend;
    logic                   cmd_err_q;
    logic [1:0]             occ;
    logic [1:0]             slots;
    logic                   pop;
    logic                   can_issue;
    logic                   issue;
    logic                   w_last;
    logic                   x_last;
    logic                   cmd_bad;
    logic                   drained;
    logic [KK_BITS-1:0]     kk;
    logic [INW-1:0]         push_data;
    logic [K_BITS:0]        tuser_w;

    assign cmd_bad = (CMD_K == '0) || (int'(CMD_K) > MAXK) ||
                     (int'(CMD_K) > R) || (int'(CMD_K) > C);

    assign kk     = KK_BITS'(k_q) * KK_BITS'(k_q);
    assign w_last = ({1'b0, w_cnt} == kk - KK_BITS'(1));
    assign x_last = (x_cnt == X_ADDR_BITS'(R * C - 1));

    // A word leaving the buffer this cycle frees its slot for a new read,
    // which is what allows one word per cycle with only two entries.
    assign pop       = OUTPUT_TVALID & OUTPUT_TREADY;
    assign slots     = occ - 2'(pop) + 2'(pend);
    assign can_issue = ~slots[1];
    assign issue     = can_issue && (state inside {SEND_W, SEND_B, SEND_X});
    assign drained   = !pend && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    assign W_RD_EN   = (state == SEND_W) && can_issue;
    assign X_RD_EN   = (state == SEND_X) && can_issue;
    assign W_RD_ADDR = w_cnt;
    assign X_RD_ADDR = x_cnt;
    assign CMD_READY = (state == IDLE);
    assign DONE      = (state == conv_pkg::DONE);
    assign CMD_ERR   = cmd_err_q;

    always_comb begin
        src_now = SRC_X;
        case (state)
            SEND_W:  src_now = SRC_W;
            SEND_B:  src_now = SRC_B;
            default: src_now = SRC_X;
        endcase
    end

    always_comb begin
        push_data = X_RD_DATA;
        case (pend_src)
            SRC_W:   push_data = W_RD_DATA;
            SRC_B:   push_data = b_q;
            default: push_data = X_RD_DATA;
        endcase
    end

    always_comb begin
        tuser_w = '0;
        tuser_w[TUSER_NEWW_BIT]        = new_w_q;
        tuser_w[TUSER_K_LSB +: K_BITS] = k_q;
        OUTPUT_TUSER = OUTPUT_TVALID ? tuser_w : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pend_src  <= SRC_W;
            k_q       <= '0;
            new_w_q   <= 1'b0;
            b_q       <= '0;
            w_cnt     <= '0;
            x_cnt     <= '0;
            pend      <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            pend      <= issue;
            if (issue) begin
                pend_src <= src_now;
            end
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        k_q     <= CMD_K;
                        new_w_q <= CMD_NEW_W;
                        b_q     <= CMD_B;
                        if (cmd_bad) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            state <= CMD_NEW_W ? SEND_W : SEND_X;
                        end
                    end
                end
                SEND_W: begin
                    if (issue) begin
                        if (w_last) begin
                            w_cnt <= '0;
                            state <= SEND_B;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                SEND_B: begin
                    if (issue) begin
                        state <= SEND_X;
                    end
                end
                SEND_X: begin
                    if (issue) begin
                        if (x_last) begin
                            x_cnt <= '0;
                            state <= DRAIN;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state <= conv_pkg::DONE;
                    end
                end
                conv_pkg::DONE: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

    axis_skid2 #(
        .W(INW)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pend),
        .push_data (push_data),
        .ready     (OUTPUT_TREADY),
        .valid     (OUTPUT_TVALID),
        .data      (OUTPUT_TDATA),
        .occ       (occ)
    );

endmodule

// File: tb/tb_conv_stream_tx.sv
// Scoreboard bench for conv_stream_tx with small R x C and simple RAM models.
module tb_conv_stream_tx;

    localparam int INW         = 24;
    localparam int R           = 4;
    localparam int C           = 5;
    localparam int MAXK        = 9;
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int X_ADDR_BITS = $clog2(R * C);
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK);
    localparam int TU_W        = K_BITS + 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [K_BITS-1:0]      cmd_k;
    logic                   cmd_new_w;
    logic [INW-1:0]         cmd_b;
    logic [X_ADDR_BITS-1:0] x_rd_addr;
    logic                   x_rd_en;
    logic [INW-1:0]         x_rd_data;
    logic [W_ADDR_BITS-1:0] w_rd_addr;
    logic                   w_rd_en;
    logic [INW-1:0]         w_rd_data;
    logic [INW-1:0]         tdata;
    logic                   tvalid;
    logic [TU_W-1:0]        tuser;
    logic                   tready;
    logic                   done;
    logic                   cmd_err;

    conv_stream_tx #(
        .INW(INW), .R(R), .C(C), .MAXK(MAXK)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .CMD_VALID     (cmd_valid),
        .CMD_READY     (cmd_ready),
        .CMD_K         (cmd_k),
        .CMD_NEW_W     (cmd_new_w),
        .CMD_B         (cmd_b),
        .X_RD_ADDR     (x_rd_addr),
        .X_RD_EN       (x_rd_en),
        .X_RD_DATA     (x_rd_data),
        .W_RD_ADDR     (w_rd_addr),
        .W_RD_EN       (w_rd_en),
        .W_RD_DATA     (w_rd_data),
        .OUTPUT_TDATA  (tdata),
        .OUTPUT_TVALID (tvalid),
        .OUTPUT_TUSER  (tuser),
        .OUTPUT_TREADY (tready),
        .DONE          (done),
        .CMD_ERR       (cmd_err)
    );

    always #5 clk = ~clk;

    // RAM models: W[i] = i, X[i] = 100 + i, one cycle of read latency.
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= INW'(int'(w_rd_addr));
        if (x_rd_en) x_rd_data <= INW'(int'(x_rd_addr) + 100);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [TU_W+INW-1:0] sb[$];

    int cyc = 0;
    int acc_cyc, first_cyc, last_cyc, done_cyc, rel_cyc;
    int first_seen = 0;
    int n_w = 0, n_x = 0, n_t = 0, cur_neww = 0;
    int done_cnt = 0, err_cnt = 0;
    int any_tvalid = 0;
    logic            prev_stall = 1'b0;
    logic [INW-1:0]  prev_data;
    logic [TU_W-1:0] prev_user;

    always @(negedge clk) begin
        logic [TU_W+INW-1:0] item;
        int popn;
        cyc++;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc; first_seen = 0;
                n_w = 0; n_x = 0; n_t = 0;
                cur_neww = cmd_new_w ? 1 : 0;
            end
            if (tvalid) any_tvalid = 1;
            if (tvalid && first_seen == 0) begin
                first_seen = 1;
                first_cyc  = cyc;
            end
            if (prev_stall) begin
                check_eq("stall_valid", tvalid, 1);
                check_eq("stall_data", tdata, prev_data);
                check_eq("stall_user", tuser, prev_user);
            end
            popn = (tvalid && tready) ? 1 : 0;
            if (w_rd_en) begin
                check_eq("w_credit", (n_w - n_t - popn) < 2, 1);
                n_w++;
            end
            if (x_rd_en) begin
                check_eq("x_credit", (n_w + cur_neww + n_x - n_t - popn) < 2, 1);
                n_x++;
            end
            if (tvalid && tready) begin
                check_eq("sb_avail", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    item = sb.pop_front();
                    check_eq("tdata", tdata, item[INW-1:0]);
                    check_eq("tuser", tuser, item[TU_W+INW-1:INW]);
                end
                n_t++;
                last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cmd_err) err_cnt++;
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_user  = tuser;
        end
    end

    // mode 0: TREADY high, 1: random TREADY, 2: TREADY low for 10 cycles
    task automatic run_txn(input int k, input int neww, input int b, input int mode);
        logic [TU_W-1:0] u;
        int total, done0;
        u     = TU_W'(k * 2 + neww);
        total = (neww != 0 ? k * k + 1 : 0) + R * C;
        if (neww != 0) begin
            for (int i = 0; i < k * k; i++) sb.push_back({u, INW'(i)});
            sb.push_back({u, INW'(b)});
        end
        for (int i = 0; i < R * C; i++) sb.push_back({u, INW'(100 + i)});
        done0 = done_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_k     = K_BITS'(k);
        cmd_new_w = (neww != 0);
        cmd_b     = INW'(b);
        tready    = (mode != 2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 400 && done_cnt == done0; i++) begin
            if (mode == 1) tready = ($urandom_range(0, 1) == 1);
            if (mode == 2 && i == 10) begin
                check_eq("hold_valid", tvalid, 1);
                check_eq("hold_data", tdata, INW'(0));
                check_eq("hold_user", tuser, u);
                check_eq("hold_no_x", n_x, 0);
                tready  = 1'b1;
                rel_cyc = cyc + 1;
            end
            @(posedge clk); #1;
        end
        check_eq("done_once", done_cnt - done0, 1);
        check_eq("beats", n_t, total);
        check_eq("sb_left", sb.size(), 0);
        check_eq("done_lat", done_cyc - last_cyc, 1);
        // TVALID rises at the edge starting the first sampled cycle
        check_eq("first_lat", (first_cyc - 1) - acc_cyc, 2);
        check_eq("w_reads", n_w, (neww != 0) ? k * k : 0);
        check_eq("x_reads", n_x, R * C);
        if (mode == 0) check_eq("rate", last_cyc - first_cyc, total - 1);
        if (mode == 2) check_eq("rate_rel", last_cyc - rel_cyc, total - 1);
        check_eq("done_low", done, 0);
        check_eq("ready_back", cmd_ready, 1);
        sb.delete();
    endtask

    task automatic run_err(input int k);
        int e0;
        e0 = err_cnt;
        any_tvalid = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_k     = K_BITS'(k);
        cmd_new_w = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("err_pulse", err_cnt - e0, 1);
        check_eq("err_quiet", any_tvalid, 0);
        check_eq("err_ready", cmd_ready, 1);
        check_eq("err_reads", n_w + n_x, 0);
    endtask

    initial begin
        int d0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_k     = '0;
        cmd_new_w = 1'b0;
        cmd_b     = '0;
        tready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_tdata", tdata, 0);
        check_eq("rst_tuser", tuser, 0);
        check_eq("rst_x_en", x_rd_en, 0);
        check_eq("rst_w_en", w_rd_en, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", cmd_err, 0);
        check_eq("rst_ready", cmd_ready, 1);
        reset_n = 1'b1;

        run_txn(3, 1, -7, 0);
        run_txn(3, 0, 5, 0);
        run_txn(2, 1, 123, 1);
        run_err(0);
        run_err(MAXK + 1);

        // Stall in SEND_X with two words buffered, then abort with reset.
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_k     = K_BITS'(1);
        cmd_new_w = 1'b0;
        tready    = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("abort_valid", tvalid, 1);
        check_eq("abort_x", n_x, 2);
        d0 = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_tvalid", tvalid, 0);
        check_eq("abort_tdata", tdata, 0);
        check_eq("abort_ready", cmd_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tready  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_nodone", done_cnt - d0, 0);
        sb.delete();

        run_txn(1, 1, -1, 0);
        run_txn(1, 1, 42, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
